// File: rtl/ahb_m2s1_arbiter.sv
// rtl/ahb_m2s1_arbiter.sv - two-master, one-slave AHB-Lite arbiter with per-master holding stage
module ahb_m2s1_arbiter #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int ARB_MODE   = 0
) (
    input  logic                  CLK,
    input  logic                  RSTN,
    input  logic [ADDR_WIDTH-1:0] M0_HADDR,
    input  logic [1:0]            M0_HTRANS,
    input  logic                  M0_HWRITE,
    input  logic [2:0]            M0_HSIZE,
    input  logic [DATA_WIDTH-1:0] M0_HWDATA,
    output logic [DATA_WIDTH-1:0] M0_HRDATA,
    output logic                  M0_HREADY,
    output logic                  M0_HRESP,
    input  logic [ADDR_WIDTH-1:0] M1_HADDR,
    input  logic [1:0]            M1_HTRANS,
    input  logic                  M1_HWRITE,
    input  logic [2:0]            M1_HSIZE,
    input  logic [DATA_WIDTH-1:0] M1_HWDATA,
    output logic [DATA_WIDTH-1:0] M1_HRDATA,
    output logic                  M1_HREADY,
    output logic                  M1_HRESP,
    output logic [ADDR_WIDTH-1:0] S_HADDR,
    output logic [1:0]            S_HTRANS,
    output logic                  S_HWRITE,
    output logic [2:0]            S_HSIZE,
    output logic [DATA_WIDTH-1:0] S_HWDATA,
    output logic                  S_HREADY,
    input  logic                  S_HREADYOUT,
    input  logic [DATA_WIDTH-1:0] S_HRDATA,
    input  logic                  S_HRESP
);

    localparam logic [1:0] TR_IDLE = 2'b00;
    localparam logic [1:0] TR_SEQ  = 2'b11;

    logic [ADDR_WIDTH-1:0] m_haddr  [2];
    logic [1:0]            m_htrans [2];
    logic                  m_hwrite [2];
    logic [2:0]            m_hsize  [2];

    assign m_haddr[0]  = M0_HADDR;
    assign m_haddr[1]  = M1_HADDR;
    assign m_htrans[0] = M0_HTRANS;
    assign m_htrans[1] = M1_HTRANS;
    assign m_hwrite[0] = M0_HWRITE;
    assign m_hwrite[1] = M1_HWRITE;
    assign m_hsize[0]  = M0_HSIZE;
    assign m_hsize[1]  = M1_HSIZE;

    // Holding stage state and arbitration history (grant/last_grant: 0 = M0, 1 = M1)
    logic [1:0]            pend;
    logic [ADDR_WIDTH-1:0] h_addr  [2];
    logic [1:0]            h_trans [2];
    logic                  h_write [2];
    logic [2:0]            h_size  [2];
    logic                  grant;
    logic                  last_grant;
    logic [1:0]            data_owner;
    logic                  dphase_valid;

    logic [1:0]            hready_int;
    logic [1:0]            live;
    logic [1:0]            req;
    logic [1:0]            capture;
    logic [ADDR_WIDTH-1:0] e_addr  [2];
    logic [1:0]            e_trans [2];
    logic                  e_write [2];
    logic [2:0]            e_size  [2];
    logic                  holder_seq;
    logic                  arb;
    logic                  sel;
    logic                  sel_req;
    logic                  fwd;

    // Live requests are gated by RSTN so the slave sees IDLE the moment reset asserts.
    // BUSY has HTRANS[1]=0 and therefore never counts as a request.
    always_comb begin
        for (int i = 0; i < 2; i++) begin
            hready_int[i] = pend[i] ? 1'b0 : (data_owner[i] ? S_HREADYOUT : 1'b1);
            live[i]       = RSTN & m_htrans[i][1] & hready_int[i];
            req[i]        = pend[i] | live[i];
            e_addr[i]     = pend[i] ? h_addr[i]  : m_haddr[i];
            e_trans[i]    = pend[i] ? h_trans[i] : m_htrans[i];
            e_write[i]    = pend[i] ? h_write[i] : m_hwrite[i];
            e_size[i]     = pend[i] ? h_size[i]  : m_hsize[i];
        end
    end

    always_comb begin
        holder_seq = req[grant] && (e_trans[grant] == TR_SEQ);
        arb        = grant;
        if (!holder_seq) begin
            if (ARB_MODE == 0) begin
                if (req[0] && req[1]) begin
                    arb = ~last_grant;
                end else if (req[0]) begin
                    arb = 1'b0;
                end else if (req[1]) begin
                    arb = 1'b1;
                end
            end else begin
                if (req[0]) begin
                    arb = 1'b0;
                end else if (req[1]) begin
                    arb = 1'b1;
                end
            end
        end
        // While the slave stalls the grant is frozen; any live request is captured instead.
        sel        = S_HREADYOUT ? arb : grant;
        sel_req    = req[sel];
        fwd        = S_HREADYOUT & sel_req;
        capture[0] = live[0] & ~(fwd & ~sel);
        capture[1] = live[1] & ~(fwd & sel);
    end

    assign S_HTRANS  = sel_req ? e_trans[sel] : TR_IDLE;
    assign S_HADDR   = sel_req ? e_addr[sel]  : '0;
    assign S_HWRITE  = sel_req ? e_write[sel] : 1'b0;
    assign S_HSIZE   = sel_req ? e_size[sel]  : 3'd0;
    assign S_HWDATA  = data_owner[1] ? M1_HWDATA : (data_owner[0] ? M0_HWDATA : '0);
    assign S_HREADY  = S_HREADYOUT;
    assign M0_HRDATA = S_HRDATA;
    assign M1_HRDATA = S_HRDATA;
    assign M0_HREADY = hready_int[0];
    assign M1_HREADY = hready_int[1];
    assign M0_HRESP  = dphase_valid & data_owner[0] & S_HRESP;
    assign M1_HRESP  = dphase_valid & data_owner[1] & S_HRESP;

    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            pend         <= '0;
            grant        <= 1'b0;
            last_grant   <= 1'b1;
            data_owner   <= '0;
            dphase_valid <= 1'b0;
            for (int i = 0; i < 2; i++) begin
                h_addr[i]  <= '0;
                h_trans[i] <= TR_IDLE;
                h_write[i] <= 1'b0;
                h_size[i]  <= 3'd0;
            end
        end else begin
            for (int i = 0; i < 2; i++) begin
                if (capture[i]) begin
                    pend[i]    <= 1'b1;
                    h_addr[i]  <= m_haddr[i];
                    h_trans[i] <= m_htrans[i];
                    h_write[i] <= m_hwrite[i];
                    h_size[i]  <= m_hsize[i];
                end else if (fwd && (sel == 1'(i))) begin
                    pend[i] <= 1'b0;
                end
            end
            if (S_HREADYOUT) begin
                grant        <= arb;
                data_owner   <= fwd ? (sel ? 2'b10 : 2'b01) : 2'b00;
                dphase_valid <= fwd;
            end
            if (fwd) begin
                last_grant <= sel;
            end
        end
    end

endmodule

// File: tb/tb_ahb_m2s1_arbiter.sv
// tb/tb_ahb_m2s1_arbiter.sv - directed and randomized checks of the two-master AHB-Lite arbiter
module tb_ahb_m2s1_arbiter;

    logic        CLK = 1'b0;
    logic        RSTN;
    logic [31:0] M0_HADDR, M1_HADDR, S_HADDR;
    logic [1:0]  M0_HTRANS, M1_HTRANS, S_HTRANS;
    logic        M0_HWRITE, M1_HWRITE, S_HWRITE;
    logic [2:0]  M0_HSIZE, M1_HSIZE, S_HSIZE;
    logic [31:0] M0_HWDATA, M1_HWDATA, S_HWDATA;
    logic [31:0] M0_HRDATA, M1_HRDATA, S_HRDATA;
    logic        M0_HREADY, M1_HREADY, M0_HRESP, M1_HRESP;
    logic        S_HREADY, S_HREADYOUT, S_HRESP;

    int vectors = 0;
    int miscompares = 0;

    typedef struct packed {
        logic [31:0] addr;
        logic [1:0]  trans;
        logic        wr;
        logic [31:0] wdata;
    } xfer_t;

    always #5 CLK = ~CLK;

    ahb_m2s1_arbiter #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .ARB_MODE(0)) dut (
        .CLK(CLK), .RSTN(RSTN),
        .M0_HADDR(M0_HADDR), .M0_HTRANS(M0_HTRANS), .M0_HWRITE(M0_HWRITE), .M0_HSIZE(M0_HSIZE),
        .M0_HWDATA(M0_HWDATA), .M0_HRDATA(M0_HRDATA), .M0_HREADY(M0_HREADY), .M0_HRESP(M0_HRESP),
        .M1_HADDR(M1_HADDR), .M1_HTRANS(M1_HTRANS), .M1_HWRITE(M1_HWRITE), .M1_HSIZE(M1_HSIZE),
        .M1_HWDATA(M1_HWDATA), .M1_HRDATA(M1_HRDATA), .M1_HREADY(M1_HREADY), .M1_HRESP(M1_HRESP),
        .S_HADDR(S_HADDR), .S_HTRANS(S_HTRANS), .S_HWRITE(S_HWRITE), .S_HSIZE(S_HSIZE),
        .S_HWDATA(S_HWDATA), .S_HREADY(S_HREADY), .S_HREADYOUT(S_HREADYOUT),
        .S_HRDATA(S_HRDATA), .S_HRESP(S_HRESP)
    );

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic idle_masters();
        M0_HTRANS = 2'b00; M0_HADDR = '0; M0_HWRITE = 1'b0; M0_HSIZE = 3'd2; M0_HWDATA = '0;
        M1_HTRANS = 2'b00; M1_HADDR = '0; M1_HWRITE = 1'b0; M1_HSIZE = 3'd2; M1_HWDATA = '0;
    endtask

    task automatic do_reset();
        RSTN = 1'b0;
        idle_masters();
        S_HREADYOUT = 1'b1; S_HRESP = 1'b0; S_HRDATA = '0;
        repeat (2) @(posedge CLK);
        #1;
        RSTN = 1'b1;
    endtask

    task automatic test_reset();
        do_reset();
        RSTN = 1'b0;
        M0_HTRANS = 2'b10; M0_HADDR = 32'h0000_0040;
        #2;
        vectors++; if (S_HTRANS !== 2'b00) begin miscompares++; $display("FAIL reset_htrans: got %b want 00", S_HTRANS); end
        vectors++; if (M0_HREADY !== 1'b1) begin miscompares++; $display("FAIL reset_m0_hready: got %b want 1", M0_HREADY); end
        vectors++; if (M1_HREADY !== 1'b1) begin miscompares++; $display("FAIL reset_m1_hready: got %b want 1", M1_HREADY); end
        vectors++; if ({M0_HRESP, M1_HRESP} !== 2'b00) begin miscompares++; $display("FAIL reset_hresp: got %b want 00", {M0_HRESP, M1_HRESP}); end
        vectors++; if (S_HWDATA !== 32'h0) begin miscompares++; $display("FAIL reset_hwdata: got %h want 0", S_HWDATA); end
        vectors++; if (S_HADDR !== 32'h0) begin miscompares++; $display("FAIL reset_haddr: got %h want 0", S_HADDR); end
        tick();
        idle_masters();
        RSTN = 1'b1;
    endtask

    task automatic test_single_read();
        logic [31:0] rd;
        rd = $urandom;
        do_reset();
        M0_HTRANS = 2'b10; M0_HADDR = 32'h2000_0000; M0_HWRITE = 1'b0;
        #1;
        vectors++; if (S_HADDR !== 32'h2000_0000) begin miscompares++; $display("FAIL single_haddr: got %h want 20000000", S_HADDR); end
        vectors++; if (S_HTRANS !== 2'b10) begin miscompares++; $display("FAIL single_htrans: got %b want 10", S_HTRANS); end
        vectors++; if (M0_HREADY !== 1'b1) begin miscompares++; $display("FAIL single_hready_a: got %b want 1", M0_HREADY); end
        tick();
        M0_HTRANS = 2'b00; S_HRDATA = rd;
        #1;
        vectors++; if (M0_HRDATA !== rd) begin miscompares++; $display("FAIL single_hrdata: got %h want %h", M0_HRDATA, rd); end
        vectors++; if (M0_HREADY !== 1'b1) begin miscompares++; $display("FAIL single_hready_d: got %b want 1", M0_HREADY); end
        vectors++; if (S_HTRANS !== 2'b00) begin miscompares++; $display("FAIL single_idle: got %b want 00", S_HTRANS); end
        tick();
    endtask

    task automatic test_simultaneous();
        logic [31:0] d0, d1;
        d0 = $urandom; d1 = $urandom;
        do_reset();
        M0_HTRANS = 2'b10; M0_HADDR = 32'h100; M0_HWRITE = 1'b1;
        M1_HTRANS = 2'b10; M1_HADDR = 32'h200; M1_HWRITE = 1'b1;
        #1;
        vectors++; if (S_HADDR !== 32'h100) begin miscompares++; $display("FAIL simul_first: got %h want 100", S_HADDR); end
        vectors++; if (M1_HREADY !== 1'b1) begin miscompares++; $display("FAIL simul_m1_accept: got %b want 1", M1_HREADY); end
        tick();
        M0_HTRANS = 2'b00; M1_HTRANS = 2'b00; M0_HWDATA = d0; M1_HWDATA = d1;
        #1;
        vectors++; if (S_HADDR !== 32'h200 || S_HTRANS !== 2'b10 || S_HWRITE !== 1'b1) begin miscompares++; $display("FAIL simul_second: got %h/%b/%b want 200/10/1", S_HADDR, S_HTRANS, S_HWRITE); end
        vectors++; if (S_HWDATA !== d0) begin miscompares++; $display("FAIL simul_wdata0: got %h want %h", S_HWDATA, d0); end
        vectors++; if (M1_HREADY !== 1'b0) begin miscompares++; $display("FAIL simul_m1_stall: got %b want 0", M1_HREADY); end
        vectors++; if (M0_HREADY !== 1'b1) begin miscompares++; $display("FAIL simul_m0_ready: got %b want 1", M0_HREADY); end
        tick();
        #1;
        vectors++; if (S_HWDATA !== d1) begin miscompares++; $display("FAIL simul_wdata1: got %h want %h", S_HWDATA, d1); end
        vectors++; if (M1_HREADY !== 1'b1) begin miscompares++; $display("FAIL simul_m1_done: got %b want 1", M1_HREADY); end
        tick();
    endtask

    task automatic test_burst();
        do_reset();
        for (int b = 0; b < 5; b++) begin
            if (b < 4) begin
                M0_HTRANS = (b == 0) ? 2'b10 : 2'b11; M0_HADDR = 32'h400 + 32'(b * 4);
            end else begin
                M0_HTRANS = 2'b00;
            end
            M1_HTRANS = (b == 1) ? 2'b10 : 2'b00; M1_HADDR = 32'h800;
            #1;
            if (b < 4) begin
                vectors++; if (S_HTRANS !== M0_HTRANS || S_HADDR !== M0_HADDR) begin miscompares++; $display("FAIL burst_beat%0d: got %b/%h want %b/%h", b, S_HTRANS, S_HADDR, M0_HTRANS, M0_HADDR); end
            end else begin
                vectors++; if (S_HTRANS !== 2'b10 || S_HADDR !== 32'h800) begin miscompares++; $display("FAIL burst_m1_after: got %b/%h want 10/800", S_HTRANS, S_HADDR); end
            end
            if (b == 2) begin
                vectors++; if (M1_HREADY !== 1'b0) begin miscompares++; $display("FAIL burst_m1_held: got %b want 0", M1_HREADY); end
            end
            tick();
        end
        M1_HTRANS = 2'b00;
        tick();
    endtask

    task automatic test_wait_states();
        logic [31:0] r1, r0;
        r1 = $urandom; r0 = $urandom;
        do_reset();
        M1_HTRANS = 2'b10; M1_HADDR = 32'h300;
        tick();
        M1_HTRANS = 2'b00; S_HREADYOUT = 1'b0;
        M0_HTRANS = 2'b10; M0_HADDR = 32'h500;
        #1;
        vectors++; if (M1_HREADY !== 1'b0) begin miscompares++; $display("FAIL wait_m1_w1: got %b want 0", M1_HREADY); end
        vectors++; if (M0_HREADY !== 1'b1) begin miscompares++; $display("FAIL wait_m0_accept: got %b want 1", M0_HREADY); end
        tick();
        M0_HTRANS = 2'b00;
        #1;
        vectors++; if (M1_HREADY !== 1'b0) begin miscompares++; $display("FAIL wait_m1_w2: got %b want 0", M1_HREADY); end
        vectors++; if (M0_HREADY !== 1'b0) begin miscompares++; $display("FAIL wait_m0_pend: got %b want 0", M0_HREADY); end
        tick();
        S_HREADYOUT = 1'b1; S_HRDATA = r1;
        #1;
        vectors++; if (M1_HREADY !== 1'b1 || M1_HRDATA !== r1) begin miscompares++; $display("FAIL wait_m1_done: got %b/%h want 1/%h", M1_HREADY, M1_HRDATA, r1); end
        vectors++; if (S_HTRANS !== 2'b10 || S_HADDR !== 32'h500) begin miscompares++; $display("FAIL wait_m0_fwd: got %b/%h want 10/500", S_HTRANS, S_HADDR); end
        vectors++; if (M0_HREADY !== 1'b0) begin miscompares++; $display("FAIL wait_m0_still: got %b want 0", M0_HREADY); end
        tick();
        S_HRDATA = r0;
        #1;
        vectors++; if (M0_HREADY !== 1'b1 || M0_HRDATA !== r0) begin miscompares++; $display("FAIL wait_m0_done: got %b/%h want 1/%h", M0_HREADY, M0_HRDATA, r0); end
        tick();
    endtask

    task automatic test_error();
        do_reset();
        M0_HTRANS = 2'b10; M0_HADDR = 32'h600; M0_HWRITE = 1'b1;
        tick();
        M0_HTRANS = 2'b00; M0_HWDATA = $urandom;
        M1_HTRANS = 2'b10; M1_HADDR = 32'h700; M1_HWRITE = 1'b1;
        S_HREADYOUT = 1'b0; S_HRESP = 1'b1;
        #1;
        vectors++; if ({M0_HRESP, M0_HREADY} !== 2'b10) begin miscompares++; $display("FAIL err_cycle1: got resp/ready %b want 10", {M0_HRESP, M0_HREADY}); end
        vectors++; if (M1_HRESP !== 1'b0) begin miscompares++; $display("FAIL err_m1_c1: got %b want 0", M1_HRESP); end
        tick();
        M1_HTRANS = 2'b00; S_HREADYOUT = 1'b1;
        #1;
        vectors++; if ({M0_HRESP, M0_HREADY} !== 2'b11) begin miscompares++; $display("FAIL err_cycle2: got resp/ready %b want 11", {M0_HRESP, M0_HREADY}); end
        vectors++; if (M1_HRESP !== 1'b0) begin miscompares++; $display("FAIL err_m1_c2: got %b want 0", M1_HRESP); end
        vectors++; if (S_HTRANS !== 2'b10 || S_HADDR !== 32'h700) begin miscompares++; $display("FAIL err_m1_fwd: got %b/%h want 10/700", S_HTRANS, S_HADDR); end
        tick();
        S_HRESP = 1'b0;
        #1;
        vectors++; if (M0_HRESP !== 1'b0 || M1_HREADY !== 1'b1) begin miscompares++; $display("FAIL err_after: got resp %b m1 ready %b want 0/1", M0_HRESP, M1_HREADY); end
        tick();
    endtask

    task automatic test_reset_mid();
        do_reset();
        M0_HTRANS = 2'b10; M0_HADDR = 32'h100;
        tick();
        M0_HTRANS = 2'b00; S_HREADYOUT = 1'b0;
        M1_HTRANS = 2'b10; M1_HADDR = 32'h200;
        tick();
        M1_HTRANS = 2'b00;
        #1;
        vectors++; if ({M0_HREADY, M1_HREADY} !== 2'b00) begin miscompares++; $display("FAIL rstmid_pre: got %b want 00", {M0_HREADY, M1_HREADY}); end
        RSTN = 1'b0;
        #1;
        vectors++; if (S_HTRANS !== 2'b00) begin miscompares++; $display("FAIL rstmid_htrans: got %b want 00", S_HTRANS); end
        vectors++; if ({M0_HREADY, M1_HREADY} !== 2'b11) begin miscompares++; $display("FAIL rstmid_hready: got %b want 11", {M0_HREADY, M1_HREADY}); end
        tick();
        RSTN = 1'b1; S_HREADYOUT = 1'b1;
        for (int c = 0; c < 3; c++) begin
            #1;
            vectors++; if (S_HTRANS !== 2'b00 || M1_HREADY !== 1'b1) begin miscompares++; $display("FAIL rstmid_stale%0d: got %b/%b want 00/1", c, S_HTRANS, M1_HREADY); end
            tick();
        end
    endtask

    // Masters issue random singles and INCR4 bursts into disjoint regions (bit 8 = master);
    // each master checks its reads against its own write history, the slave checks order and data.
    task automatic test_random(input int ncycles);
        xfer_t       q0[$], q1[$], x;
        logic [31:0] smem [128];
        logic [31:0] rmem [128];
        logic [31:0] a_addr [2], a_wdata [2], d_addr [2], d_wdata [2], rd [2];
        logic [1:0]  a_trans [2];
        logic        a_wr [2], d_act [2], d_wr [2], hr [2];
        int          bl [2];
        logic        s_act, s_wr, last_fwd, gen;
        logic [31:0] s_addr, s_wexp;
        int          mm, w;
        for (int i = 0; i < 128; i++) begin smem[i] = $urandom; rmem[i] = smem[i]; end
        for (int m = 0; m < 2; m++) begin
            a_addr[m] = '0; a_wdata[m] = '0; d_addr[m] = '0; d_wdata[m] = '0; a_trans[m] = 2'b00;
            a_wr[m] = 1'b0; d_act[m] = 1'b0; d_wr[m] = 1'b0; bl[m] = 0;
        end
        s_act = 1'b0; s_wr = 1'b0; s_addr = '0; s_wexp = '0; last_fwd = 1'b0;
        do_reset();
        for (int cyc = 0; cyc < ncycles + 40; cyc++) begin
            gen = (cyc < ncycles);
            M0_HTRANS = a_trans[0]; M0_HADDR = a_addr[0]; M0_HWRITE = a_wr[0];
            M0_HWDATA = (d_act[0] && d_wr[0]) ? d_wdata[0] : $urandom;
            M1_HTRANS = a_trans[1]; M1_HADDR = a_addr[1]; M1_HWRITE = a_wr[1];
            M1_HWDATA = (d_act[1] && d_wr[1]) ? d_wdata[1] : $urandom;
            S_HREADYOUT = s_act ? ($urandom_range(0, 3) != 0) : 1'b1;
            S_HRDATA = (s_act && !s_wr) ? smem[s_addr[8:2]] : $urandom;
            #4;
            hr[0] = M0_HREADY; hr[1] = M1_HREADY; rd[0] = M0_HRDATA; rd[1] = M1_HRDATA;
            for (int m = 0; m < 2; m++) begin
                if (hr[m]) begin
                    if (d_act[m]) begin
                        if (d_wr[m]) begin
                            rmem[d_addr[m][8:2]] = d_wdata[m];
                        end else begin
                            vectors++; if (rd[m] !== rmem[d_addr[m][8:2]]) begin miscompares++; $display("FAIL rnd_rdata m%0d @%h: got %h want %h", m, d_addr[m], rd[m], rmem[d_addr[m][8:2]]); end
                        end
                        d_act[m] = 1'b0;
                    end
                    if (a_trans[m][1]) begin
                        x = '{addr: a_addr[m], trans: a_trans[m], wr: a_wr[m], wdata: a_wdata[m]};
                        if (m == 0) q0.push_back(x); else q1.push_back(x);
                        d_act[m] = 1'b1; d_wr[m] = a_wr[m]; d_addr[m] = a_addr[m]; d_wdata[m] = a_wdata[m];
                    end
                    if (bl[m] > 0) begin
                        a_trans[m] = 2'b11; a_addr[m] = a_addr[m] + 32'd4; a_wdata[m] = $urandom; bl[m]--;
                    end else if (gen && $urandom_range(0, 2) != 0) begin
                        a_trans[m] = 2'b10; a_wr[m] = 1'($urandom); a_wdata[m] = $urandom;
                        if ($urandom_range(0, 1) == 1) begin bl[m] = 3; w = $urandom_range(0, 60); end
                        else w = $urandom_range(0, 63);
                        a_addr[m] = (32'(m) << 8) | (32'(w) << 2);
                    end else begin
                        a_trans[m] = 2'b00;
                    end
                end
            end
            if (S_HREADYOUT) begin
                if (s_act && s_wr) begin
                    vectors++; if (S_HWDATA !== s_wexp) begin miscompares++; $display("FAIL rnd_wdata @%h: got %h want %h", s_addr, S_HWDATA, s_wexp); end
                    smem[s_addr[8:2]] = S_HWDATA;
                end
                s_act = 1'b0;
                if (S_HTRANS[1]) begin
                    mm = int'(S_HADDR[8]);
                    vectors++;
                    if ((mm == 0 && q0.size() == 0) || (mm == 1 && q1.size() == 0)) begin
                        miscompares++; $display("FAIL rnd_unexpected: got addr %h trans %b want no transfer", S_HADDR, S_HTRANS);
                    end else begin
                        x = (mm == 0) ? q0.pop_front() : q1.pop_front();
                        if ({S_HADDR, S_HTRANS, S_HWRITE} !== {x.addr, x.trans, x.wr}) begin miscompares++; $display("FAIL rnd_order m%0d: got %h/%b/%b want %h/%b/%b", mm, S_HADDR, S_HTRANS, S_HWRITE, x.addr, x.trans, x.wr); end
                        if (x.trans == 2'b11) begin
                            vectors++; if (last_fwd !== 1'(mm)) begin miscompares++; $display("FAIL rnd_burst_break: got prev master %0d want %0d", last_fwd, mm); end
                        end
                        s_act = 1'b1; s_wr = S_HWRITE; s_addr = S_HADDR; s_wexp = x.wdata; last_fwd = 1'(mm);
                    end
                end
            end
            @(posedge CLK);
            #1;
        end
        vectors++; if (q0.size() + q1.size() != 0) begin miscompares++; $display("FAIL rnd_drain: got %0d outstanding want 0", q0.size() + q1.size()); end
        idle_masters();
        tick();
    endtask

    initial begin
        RSTN = 1'b0;
        idle_masters();
        S_HREADYOUT = 1'b1; S_HRESP = 1'b0; S_HRDATA = '0;
        test_reset();
        test_single_read();
        test_simultaneous();
        test_burst();
        test_wait_states();
        test_error();
        test_reset_mid();
        test_random(600);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
